trig_sampler: RTL and testbench
===============================

Name: trig_sampler

Overview:
- Parametrised, single-clock successor to the fill-once sampler.
- Continuously records samples into a circular buffer once armed. Holds a configurable number of pre-trigger samples and stops after the post-trigger region fills.
- Trigger is a masked pattern match with level, edge or immediate modes.
- Readout is by logical index: index 0 is always the oldest captured sample.
- Sits between a probed bus and a CSR/readout wrapper; the wrapper drives start/abort and consumes done/irq.

Parameters:
width, 8, sample width in bits
timeBits, 10, log2 buffer depth; depth = 2**timeBits

Ports:
clk  in  1  clock for all logic and memory
reset  in  1  synchronous, active-high reset
in_valid  in  1  sample strobe; the sample is taken only when high
in_data  in  width  sample data
start  in  1  pulse; begins a capture from IDLE or DONE
abort  in  1  pulse; returns to IDLE from any state
trig_mode  in  2  0 immediate, 1 level match, 2 edge into match, 3 edge out of match
trig_mask  in  width  bits compared by the trigger
trig_value  in  width  compare value
pre_count  in  timeBits  number of samples to keep before the trigger (0..depth-1)
busy  out  1  high in PRETRIG, ARMED or POSTTRIG
armed  out  1  high in ARMED
done  out  1  high in DONE
irq  out  1  one-cycle pulse on entering DONE
start_addr  out  timeBits  physical address of logical sample 0
r_enable  in  1  read strobe
r_addr  in  timeBits  logical read index
r_data  out  width  read data

Behaviour:
- Reset: state IDLE; busy/armed/done/irq = 0; start_addr = 0; r_data = 0; all pointers and counters = 0. Memory contents are not cleared.
- Configuration latch: trig_mode, trig_mask, trig_value and pre_count are latched on an accepted start and used for the whole capture.
- Start handling:
  - start is ignored in PRETRIG, ARMED and POSTTRIG.
  - start in DONE restarts and clears done.
  - abort wins over a simultaneous start.
- match = ((in_data ^ trig_value) & trig_mask) == 0. A mask of 0 always matches.
- prev_match:
  - Updated on every valid sample in PRETRIG and ARMED.
  - Marked invalid on start.
  - Edge modes never fire while prev_match is invalid, so the first valid sample after start cannot edge-trigger.
- Write pointer wptr: reset to 0 on start; increments once per written sample; wraps modulo depth.
- IDLE:
  - On start with pre_count = 0, go to ARMED.
  - On start with any other pre_count, go to PRETRIG with fill = 0.
- PRETRIG:
  - Each valid sample is written at wptr and increments fill.
  - Transition to ARMED in the cycle fill reaches pre_count.
  - Trigger is not evaluated.
- ARMED:
  - Each valid sample is written, and the trigger is evaluated on that same sample.
  - Trigger condition per mode:
    - mode 0: always true.
    - mode 1: true when match.
    - mode 2: true when match and prev_match is 0.
    - mode 3: true when not match and prev_match is 1.
  - On trigger:
    - trig_addr = wptr of the triggering sample.
    - start_addr = (trig_addr - pre_count) mod depth.
    - remain = depth - 1 - pre_count.
    - Go to DONE if remain = 0, otherwise to POSTTRIG.
  - The buffer wraps freely while ARMED; the oldest samples are overwritten.
- POSTTRIG:
  - Each valid sample is written and decrements remain.
  - The write that takes remain to 0 moves to DONE on the next edge.
- DONE:
  - No writes.
  - done = 1.
  - irq is high for exactly the first cycle in DONE.
- abort: from any state, go to IDLE next cycle; done = 0; no irq.
- in_valid low: nothing is written, no counters change, no trigger evaluation. Gaps are invisible in the buffer.
- Buffer contents after a capture:
  - Exactly depth samples: pre_count pre-trigger samples, the trigger sample, then depth-1-pre_count post-trigger samples.
  - The trigger sample is at logical index pre_count.
- Read port:
  - Physical address = (start_addr + r_addr) mod depth.
  - 1-cycle latency: r_data is updated on the edge after r_enable is high and holds otherwise.
  - Reads are legal in any state. Contents are defined only in DONE.
- Width rules: all address arithmetic is timeBits wide and wraps naturally. remain and fill are timeBits wide.
- Reset mid-capture behaves exactly as the reset state above. The next capture requires a new start.

Test Plan:
1. timeBits=4, width=8, pre_count=4, mode 1, mask FF, value 0x20; in_data increments from 0x00 each valid cycle, in_valid always high. Required: trigger on 0x20; start_addr=12; done after sample 0x2B; single irq pulse; reading logical 0..15 returns 0x1C..0x2B.
2. mode 0, pre_count=0, in_valid toggling every other cycle with data 0x80..0x8F on valid cycles. Required: the first valid sample triggers; logical 0..15 = 0x80..0x8F; no duplicate or skipped samples.
3. mode 2, mask 0F, value 05, pre_count=2; in_data held at 0x15 across start, then 0x10, 0x25. Required: no trigger on the initial match; trigger on 0x25 at logical index 2.
4. pre_count=15, mode 1, trigger sample 0x3A reached after more than 16 ARMED writes. Required: DONE the cycle after the trigger write; logical 15 = 0x3A; logical 0..14 = the 15 preceding samples.
5. abort mid-POSTTRIG, and start+abort asserted in the same cycle. Required: IDLE, done=0, no irq in either case; a subsequent start completes a normal capture.
6. reset asserted while ARMED, then start. Required: all outputs return to reset values; the following capture matches test 1 exactly.

Source files
------------

// File: rtl/trig_sampler.sv
//----------------------------------------------------------------------------
// trig_sampler
//
// Triggered circular-buffer sampler. Once a capture is started it records
// every valid sample into a 2**timeBits deep buffer, keeps pre_count samples
// from before the trigger, and stops once the post-trigger region is full.
// Readout is by logical index, where index 0 is the oldest captured sample.
//
// Ports:
//   clk, reset        single clock, synchronous active-high reset
//   in_valid, in_data sample strobe and sample data from the probed bus
//   start, abort      capture control pulses (abort wins over start)
//   trig_mode         0 immediate, 1 level match, 2 edge into match,
//                     3 edge out of match
//   trig_mask/value   masked pattern compare for the trigger
//   pre_count         samples to keep ahead of the trigger (0..depth-1)
//   busy/armed/done   capture status
//   irq               one-cycle pulse on entering DONE
//   start_addr        physical address of logical sample 0
//   r_enable, r_addr  logical read request
//   r_data            read data, one cycle after r_enable
//   state_dbg         current FSM state encoding, for observation only
//
// Sample interface: there is no back-pressure. A sample is consumed on every
// rising edge where in_valid is high; cycles with in_valid low are ignored
// entirely (no write, no counter change, no trigger evaluation).
//----------------------------------------------------------------------------
module trig_sampler #(
   parameter int width    = 8,
   parameter int timeBits = 10
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                in_valid,
   input  logic [width-1:0]    in_data,
   input  logic                start,
   input  logic                abort,
   input  logic [1:0]          trig_mode,
   input  logic [width-1:0]    trig_mask,
   input  logic [width-1:0]    trig_value,
   input  logic [timeBits-1:0] pre_count,
   output logic                busy,
   output logic                armed,
   output logic                done,
   output logic                irq,
   output logic [timeBits-1:0] start_addr,
   input  logic                r_enable,
   input  logic [timeBits-1:0] r_addr,
   output logic [width-1:0]    r_data,
   output logic [2:0]          state_dbg
);

   localparam int depth = 1 << timeBits;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_PRETRIG  = 3'd1,
      S_ARMED    = 3'd2,
      S_POSTTRIG = 3'd3,
      S_DONE     = 3'd4
   } state_t;

   state_t              state_q, state_d;
   logic [timeBits-1:0] wptr_q, wptr_d;
   logic [timeBits-1:0] fill_q, fill_d;
   logic [timeBits-1:0] remain_q, remain_d;
   logic [timeBits-1:0] start_addr_q, start_addr_d;
   logic                irq_q, irq_d;
   logic                prev_match_q, prev_match_d;
   logic                prev_valid_q, prev_valid_d;
   logic [1:0]          cfg_mode_q, cfg_mode_d;
   logic [width-1:0]    cfg_mask_q, cfg_mask_d;
   logic [width-1:0]    cfg_value_q, cfg_value_d;
   logic [timeBits-1:0] cfg_pre_q, cfg_pre_d;
   logic [width-1:0]    r_data_q;

   logic [width-1:0]    mem [depth];

   logic                match;
   logic                trig_fire;
   logic                capturing;
   logic                mem_we;
   logic [timeBits-1:0] wptr_inc;
   logic [timeBits-1:0] fill_inc;
   logic [timeBits-1:0] remain_at_trig;
   logic [timeBits-1:0] rd_addr;

   //-------------------------------------------------------------------------
   // Datapath helpers
   //-------------------------------------------------------------------------
   always_comb begin
      match          = ((in_data ^ cfg_value_q) & cfg_mask_q) == '0;
      capturing      = (state_q == S_PRETRIG) || (state_q == S_ARMED) ||
                       (state_q == S_POSTTRIG);
      mem_we         = in_valid && capturing && !abort && !reset;
      wptr_inc       = wptr_q + 1'b1;
      fill_inc       = fill_q + 1'b1;
      // depth-1-pre_count, computed in timeBits-wide arithmetic
      remain_at_trig = {timeBits{1'b1}} - cfg_pre_q;
      rd_addr        = start_addr_q + r_addr;
   end

   // Edge modes need a valid previous sample; prev_valid_q is cleared on
   // start so the first sample of a capture can never edge-trigger.
   always_comb begin
      trig_fire = 1'b0;
      case (cfg_mode_q)
         2'd0: trig_fire = 1'b1;
         2'd1: trig_fire = match;
         2'd2: trig_fire = match && prev_valid_q && !prev_match_q;
         2'd3: trig_fire = !match && prev_valid_q && prev_match_q;
         default: trig_fire = 1'b0;
      endcase
   end

   //-------------------------------------------------------------------------
   // Next-state logic
   //-------------------------------------------------------------------------
   always_comb begin
      state_d      = state_q;
      wptr_d       = wptr_q;
      fill_d       = fill_q;
      remain_d     = remain_q;
      start_addr_d = start_addr_q;
      prev_match_d = prev_match_q;
      prev_valid_d = prev_valid_q;
      cfg_mode_d   = cfg_mode_q;
      cfg_mask_d   = cfg_mask_q;
      cfg_value_d  = cfg_value_q;
      cfg_pre_d    = cfg_pre_q;

      if (abort) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               if (start) begin
                  cfg_mode_d   = trig_mode;
                  cfg_mask_d   = trig_mask;
                  cfg_value_d  = trig_value;
                  cfg_pre_d    = pre_count;
                  wptr_d       = '0;
                  fill_d       = '0;
                  remain_d     = '0;
                  prev_match_d = 1'b0;
                  prev_valid_d = 1'b0;
                  state_d      = (pre_count == '0) ? S_ARMED : S_PRETRIG;
               end
            end

            S_PRETRIG: begin
               if (in_valid) begin
                  wptr_d       = wptr_inc;
                  fill_d       = fill_inc;
                  prev_match_d = match;
                  prev_valid_d = 1'b1;
                  if (fill_inc == cfg_pre_q) begin
                     state_d = S_ARMED;
                  end
               end
            end

            S_ARMED: begin
               if (in_valid) begin
                  wptr_d       = wptr_inc;
                  prev_match_d = match;
                  prev_valid_d = 1'b1;
                  if (trig_fire) begin
                     // Logical 0 sits pre_count slots behind the trigger write.
                     start_addr_d = wptr_q - cfg_pre_q;
                     remain_d     = remain_at_trig;
                     state_d      = (remain_at_trig == '0) ? S_DONE : S_POSTTRIG;
                  end
               end
            end

            S_POSTTRIG: begin
               if (in_valid) begin
                  wptr_d   = wptr_inc;
                  remain_d = remain_q - 1'b1;
                  if (remain_q == {{(timeBits-1){1'b0}}, 1'b1}) begin
                     state_d = S_DONE;
                  end
               end
            end

            default: state_d = S_IDLE;
         endcase
      end

      irq_d = (state_d == S_DONE) && (state_q != S_DONE);
   end

   //-------------------------------------------------------------------------
   // State registers
   //-------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         wptr_q       <= '0;
         fill_q       <= '0;
         remain_q     <= '0;
         start_addr_q <= '0;
         irq_q        <= 1'b0;
         prev_match_q <= 1'b0;
         prev_valid_q <= 1'b0;
         cfg_mode_q   <= '0;
         cfg_mask_q   <= '0;
         cfg_value_q  <= '0;
         cfg_pre_q    <= '0;
      end else begin
         state_q      <= state_d;
         wptr_q       <= wptr_d;
         fill_q       <= fill_d;
         remain_q     <= remain_d;
         start_addr_q <= start_addr_d;
         irq_q        <= irq_d;
         prev_match_q <= prev_match_d;
         prev_valid_q <= prev_valid_d;
         cfg_mode_q   <= cfg_mode_d;
         cfg_mask_q   <= cfg_mask_d;
         cfg_value_q  <= cfg_value_d;
         cfg_pre_q    <= cfg_pre_d;
      end
   end

   //-------------------------------------------------------------------------
   // Sample memory: synchronous write, registered read with its own reset so
   // it maps onto a block RAM with a resettable output register.
   //-------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[wptr_q] <= in_data;
      end
      if (reset) begin
         r_data_q <= '0;
      end else if (r_enable) begin
         r_data_q <= mem[rd_addr];
      end
   end

   //-------------------------------------------------------------------------
   // Outputs
   //-------------------------------------------------------------------------
   always_comb begin
      busy       = capturing;
      armed      = (state_q == S_ARMED);
      done       = (state_q == S_DONE);
      irq        = irq_q;
      start_addr = start_addr_q;
      r_data     = r_data_q;
      state_dbg  = state_q;
   end

endmodule

// File: tb/tb_trig_sampler.sv
module tb_trig_sampler;

   localparam int W  = 8;
   localparam int TB = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          in_valid;
   logic [W-1:0]  in_data;
   logic          start;
   logic          abort;
   logic [1:0]    trig_mode;
   logic [W-1:0]  trig_mask;
   logic [W-1:0]  trig_value;
   logic [TB-1:0] pre_count;
   logic          busy;
   logic          armed;
   logic          done;
   logic          irq;
   logic [TB-1:0] start_addr;
   logic          r_enable;
   logic [TB-1:0] r_addr;
   logic [W-1:0]  r_data;
   logic [2:0]    state_dbg;

   int n_checks = 0;
   int n_fail   = 0;
   int irq_count = 0;
   int irq_base;

   trig_sampler #(.width(W), .timeBits(TB)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .start      (start),
      .abort      (abort),
      .trig_mode  (trig_mode),
      .trig_mask  (trig_mask),
      .trig_value (trig_value),
      .pre_count  (pre_count),
      .busy       (busy),
      .armed      (armed),
      .done       (done),
      .irq        (irq),
      .start_addr (start_addr),
      .r_enable   (r_enable),
      .r_addr     (r_addr),
      .r_data     (r_data),
      .state_dbg  (state_dbg)
   );

   // clock / reset block
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (irq === 1'b1) irq_count <= irq_count + 1;
   end

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic send(input logic [W-1:0] d, input logic v);
      in_data  = d;
      in_valid = v;
      tick();
   endtask

   task automatic do_start(input logic [1:0] m, input logic [W-1:0] mk,
                           input logic [W-1:0] vl, input logic [TB-1:0] pc);
      trig_mode  = m;
      trig_mask  = mk;
      trig_value = vl;
      pre_count  = pc;
      start      = 1'b1;
      tick();
      start      = 1'b0;
   endtask

   task automatic rd_chk(input string tag, input int idx, input logic [W-1:0] exp_v);
      r_enable = 1'b1;
      r_addr   = TB'(idx);
      tick();
      r_enable = 1'b0;
      chk($sformatf("%s[%0d]", tag, idx), 32'(r_data), 32'(exp_v));
   endtask

   // Ramp 0x00.. with mode 1, value 0x20, pre_count 4: trigger at wptr 0,
   // start_addr 12, last post-trigger sample 0x2B.
   task automatic run_t1(input string tag);
      in_valid = 1'b0;
      do_start(2'd1, 8'hFF, 8'h20, 4'd4);
      chk({tag, "_pretrig_busy"}, 32'(busy), 32'd1);
      chk({tag, "_pretrig_armed"}, 32'(armed), 32'd0);
      irq_base = irq_count;
      for (int d = 0; d <= 8'h2B; d++) begin
         send(W'(d), 1'b1);
         if (d == 2)    chk({tag, "_armed_d2"}, 32'(armed), 32'd0);
         if (d == 3)    chk({tag, "_armed_d3"}, 32'(armed), 32'd1);
         if (d == 8'h1F) chk({tag, "_armed_d1f"}, 32'(armed), 32'd1);
         if (d == 8'h20) begin
            chk({tag, "_post_armed"}, 32'(armed), 32'd0);
            chk({tag, "_post_busy"}, 32'(busy), 32'd1);
            chk({tag, "_start_addr"}, 32'(start_addr), 32'd12);
         end
         if (d == 8'h2A) chk({tag, "_done_early"}, 32'(done), 32'd0);
         if (d == 8'h2B) begin
            chk({tag, "_done"}, 32'(done), 32'd1);
            chk({tag, "_irq"}, 32'(irq), 32'd1);
         end
      end
      in_valid = 1'b0;
      tick();
      chk({tag, "_irq_drop"}, 32'(irq), 32'd0);
      chk({tag, "_done_hold"}, 32'(done), 32'd1);
      chk({tag, "_irq_count"}, 32'(irq_count - irq_base), 32'd1);
      for (int i = 0; i < 16; i++) rd_chk({tag, "_rd"}, i, W'(8'h1C + i));
   endtask

   initial begin
      reset = 1'b1; in_valid = 1'b0; in_data = '0; start = 1'b0; abort = 1'b0;
      trig_mode = '0; trig_mask = '0; trig_value = '0; pre_count = '0;
      r_enable = 1'b0; r_addr = '0;
      tick(); tick(); tick();
      reset = 1'b0;
      tick();
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_armed", 32'(armed), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_irq", 32'(irq), 32'd0);
      chk("rst_start_addr", 32'(start_addr), 32'd0);
      chk("rst_r_data", 32'(r_data), 32'd0);
      chk("rst_state", 32'(state_dbg), 32'd0);

      // Test 1
      run_t1("t1");

      // Test 2: immediate mode, pre_count 0, gapped input, restart from DONE
      do_start(2'd0, 8'hFF, 8'h00, 4'd0);
      chk("t2_done_cleared", 32'(done), 32'd0);
      chk("t2_armed", 32'(armed), 32'd1);
      irq_base = irq_count;
      for (int i = 0; i < 16; i++) begin
         send(8'hEE, 1'b0);
         send(W'(8'h80 + i), 1'b1);
         if (i == 0) begin
            chk("t2_first_trig", 32'(armed), 32'd0);
            chk("t2_start_addr", 32'(start_addr), 32'd0);
         end
         if (i == 14) chk("t2_done_early", 32'(done), 32'd0);
         if (i == 15) chk("t2_done", 32'(done), 32'd1);
      end
      in_valid = 1'b0;
      tick();
      chk("t2_irq_count", 32'(irq_count - irq_base), 32'd1);
      for (int i = 0; i < 16; i++) rd_chk("t2_rd", i, W'(8'h80 + i));

      // Test 3: edge into match, data held at a matching value across start
      in_data  = 8'h15;
      in_valid = 1'b1;
      do_start(2'd2, 8'h0F, 8'h05, 4'd2);
      send(8'h15, 1'b1);
      send(8'h15, 1'b1);
      chk("t3_armed", 32'(armed), 32'd1);
      send(8'h15, 1'b1);
      chk("t3_no_trig_held", 32'(armed), 32'd1);
      send(8'h10, 1'b1);
      chk("t3_no_trig_miss", 32'(armed), 32'd1);
      send(8'h25, 1'b1);
      chk("t3_trig", 32'(armed), 32'd0);
      chk("t3_start_addr", 32'(start_addr), 32'd2);
      for (int k = 0; k < 13; k++) send(W'(8'h40 + k), 1'b1);
      in_valid = 1'b0;
      chk("t3_done", 32'(done), 32'd1);
      tick();
      rd_chk("t3_rd", 0, 8'h15);
      rd_chk("t3_rd", 1, 8'h10);
      rd_chk("t3_rd", 2, 8'h25);
      rd_chk("t3_rd", 3, 8'h40);
      rd_chk("t3_rd", 15, 8'h4C);

      // Test 4: pre_count = depth-1, wraps many times while ARMED
      do_start(2'd1, 8'hFF, 8'h3A, 4'd15);
      for (int d = 0; d <= 8'h3A; d++) begin
         send(W'(d), 1'b1);
         if (d == 8'h0D) chk("t4_pretrig", 32'(armed), 32'd0);
         if (d == 8'h0E) chk("t4_armed", 32'(armed), 32'd1);
         if (d == 8'h39) chk("t4_done_early", 32'(done), 32'd0);
         if (d == 8'h3A) begin
            chk("t4_done", 32'(done), 32'd1);
            chk("t4_irq", 32'(irq), 32'd1);
            chk("t4_start_addr", 32'(start_addr), 32'd11);
         end
      end
      in_valid = 1'b0;
      tick();
      for (int i = 0; i < 16; i++) rd_chk("t4_rd", i, W'(8'h2B + i));

      // Test 5: abort mid-POSTTRIG, then start+abort together
      in_valid = 1'b0;
      do_start(2'd1, 8'hFF, 8'h20, 4'd4);
      irq_base = irq_count;
      for (int d = 0; d <= 8'h24; d++) send(W'(d), 1'b1);
      chk("t5_in_post", 32'(state_dbg), 32'd3);
      in_valid = 1'b0;
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("t5_abort_idle", 32'(state_dbg), 32'd0);
      chk("t5_abort_done", 32'(done), 32'd0);
      chk("t5_abort_busy", 32'(busy), 32'd0);
      start = 1'b1;
      abort = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b0;
      chk("t5_both_idle", 32'(state_dbg), 32'd0);
      chk("t5_both_busy", 32'(busy), 32'd0);
      tick(); tick();
      chk("t5_still_idle", 32'(busy), 32'd0);
      chk("t5_no_irq", 32'(irq_count - irq_base), 32'd0);
      run_t1("t5_again");

      // Test 6: reset while ARMED
      do_start(2'd1, 8'hFF, 8'h20, 4'd4);
      for (int d = 0; d < 6; d++) send(W'(d), 1'b1);
      chk("t6_armed", 32'(armed), 32'd1);
      in_valid = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("t6_busy", 32'(busy), 32'd0);
      chk("t6_armed_clr", 32'(armed), 32'd0);
      chk("t6_done", 32'(done), 32'd0);
      chk("t6_irq", 32'(irq), 32'd0);
      chk("t6_start_addr", 32'(start_addr), 32'd0);
      chk("t6_r_data", 32'(r_data), 32'd0);
      chk("t6_state", 32'(state_dbg), 32'd0);
      tick();
      chk("t6_stays_idle", 32'(busy), 32'd0);
      run_t1("t6_again");

      // final report
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
